// File: rtl/nvme_sq_feeder_if.sv
// Command-stream, SQ-write, doorbell and job-control signals between the scheduler side and the SQ feeder.
// master is the feeder; slave is the scheduler/memory/completion environment around it.
interface nvme_sq_feeder_if;
  logic        start;
  logic [31:0] num_reqs;
  logic [63:0] sq_base;
  logic        done;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [63:0] cmd_data;
  logic        sq_wr_valid;
  logic        sq_wr_ready;
  logic [63:0] sq_wr_addr;
  logic [63:0] sq_wr_data;
  logic        db_valid;
  logic        db_ready;
  logic [15:0] db_tail;
  logic        cq_head_vld;
  logic [15:0] cq_head;

  modport master (
    input  start, num_reqs, sq_base, cmd_valid, cmd_data, sq_wr_ready, db_ready,
           cq_head_vld, cq_head,
    output done, cmd_ready, sq_wr_valid, sq_wr_addr, sq_wr_data, db_valid, db_tail
  );

  modport slave (
    output start, num_reqs, sq_base, cmd_valid, cmd_data, sq_wr_ready, db_ready,
           cq_head_vld, cq_head,
    input  done, cmd_ready, sq_wr_valid, sq_wr_addr, sq_wr_data, db_valid, db_tail
  );
endinterface

// File: rtl/nvme_sq_feeder.sv
// Streams command pointers into a circular SQ, ringing the tail doorbell every BATCH entries.
// Two cycles per command plus one per ring; stalls on SQ-full, sq_wr_ready and db_ready.
module nvme_sq_feeder #(
  parameter int SQ_DEPTH    = 64,
  parameter int ENTRY_BYTES = 8,
  parameter int BATCH       = 8
) (
  input logic            aclk,
  input logic            reset,
  nvme_sq_feeder_if.master bus
);
  localparam int AW = (SQ_DEPTH > 1) ? $clog2(SQ_DEPTH) : 1;
  localparam int BW = $clog2(BATCH + 1);
  localparam int SH = $clog2(ENTRY_BYTES);
  localparam logic [AW-1:0] TAIL_ONE  = 1;
  localparam logic [BW-1:0] BATCH_ONE = 1;
  localparam logic [BW-1:0] BATCH_END = BATCH[BW-1:0];

  typedef enum logic [2:0] {IDLE, FETCH, WRITE, RING, DONE} state_t;

  state_t        state;
  logic [AW-1:0] tail;
  logic [AW-1:0] head;
  logic [AW-1:0] tail_inc;
  logic [31:0]   remaining;
  logic [BW-1:0] batch_cnt;
  logic [63:0]   base_q;
  logic          wr_valid_q;
  logic [63:0]   wr_addr_q;
  logic [63:0]   wr_data_q;
  logic          db_valid_q;
  logic [15:0]   db_tail_q;
  logic          done_q;
  logic          full;

  assign tail_inc = tail + TAIL_ONE;
  assign full     = (tail_inc == head);

  assign bus.cmd_ready   = (state == FETCH) && !full;
  assign bus.sq_wr_valid = wr_valid_q;
  assign bus.sq_wr_addr  = wr_addr_q;
  assign bus.sq_wr_data  = wr_data_q;
  assign bus.db_valid    = db_valid_q;
  assign bus.db_tail     = db_tail_q;
  assign bus.done        = done_q;

  always_ff @(posedge aclk) begin
    if (reset) begin
      state      <= IDLE;
      tail       <= '0;
      head       <= '0;
      remaining  <= '0;
      batch_cnt  <= '0;
      base_q     <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      db_valid_q <= 1'b0;
      db_tail_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // Out-of-range head reports are dropped rather than truncated.
      if (bus.cq_head_vld && (32'(bus.cq_head) < 32'(SQ_DEPTH))) begin
        head <= bus.cq_head[AW-1:0];
      end
      case (state)
        IDLE: begin
          if (bus.start) begin
            remaining <= bus.num_reqs;
            base_q    <= bus.sq_base;
            batch_cnt <= '0;
            state     <= (bus.num_reqs != 32'd0) ? FETCH : DONE;
          end
        end
        FETCH: begin
          if (bus.cmd_valid && !full) begin
            wr_data_q  <= bus.cmd_data;
            wr_addr_q  <= base_q + (64'(tail) << SH);
            wr_valid_q <= 1'b1;
            state      <= WRITE;
          end else if (full && (batch_cnt != '0)) begin
            // Publish the partial batch so the consumer can drain and free space.
            db_valid_q <= 1'b1;
            db_tail_q  <= 16'(tail);
            state      <= RING;
          end
        end
        WRITE: begin
          if (bus.sq_wr_ready) begin
            wr_valid_q <= 1'b0;
            tail       <= tail_inc;
            remaining  <= remaining - 32'd1;
            batch_cnt  <= batch_cnt + BATCH_ONE;
            if ((remaining == 32'd1) || (batch_cnt + BATCH_ONE == BATCH_END)) begin
              db_valid_q <= 1'b1;
              db_tail_q  <= 16'(tail_inc);
              state      <= RING;
            end else begin
              state <= FETCH;
            end
          end
        end
        RING: begin
          if (bus.db_ready) begin
            db_valid_q <= 1'b0;
            batch_cnt  <= '0;
            state      <= (remaining == 32'd0) ? DONE : FETCH;
          end
        end
        DONE: begin
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nvme_sq_feeder.sv
// Directed bench: a 64-deep/BATCH 8 feeder and a 4-deep/BATCH 3 feeder share one stimulus port selected by sel.
module tb_nvme_sq_feeder;
  logic aclk  = 1'b0;
  logic reset = 1'b1;
  always #5 aclk = ~aclk;

  logic        sel         = 1'b0;
  logic        start       = 1'b0;
  logic [31:0] num_reqs    = '0;
  logic [63:0] sq_base     = '0;
  logic        cmd_valid   = 1'b0;
  logic [63:0] cmd_data    = '0;
  logic        sq_wr_ready = 1'b1;
  logic        db_ready    = 1'b1;
  logic        cq_head_vld = 1'b0;
  logic [15:0] cq_head     = '0;
  logic        stall       = 1'b0;
  logic        wr_hold     = 1'b0;

  logic        done, cmd_ready, sq_wr_valid, db_valid;
  logic [63:0] sq_wr_addr, sq_wr_data;
  logic [15:0] db_tail;

  int checks = 0;
  int errors = 0;

  nvme_sq_feeder_if b0 ();
  nvme_sq_feeder_if b1 ();

  nvme_sq_feeder #(.SQ_DEPTH(64), .ENTRY_BYTES(8), .BATCH(8)) u_big (
    .aclk(aclk), .reset(reset), .bus(b0)
  );
  nvme_sq_feeder #(.SQ_DEPTH(4), .ENTRY_BYTES(8), .BATCH(3)) u_small (
    .aclk(aclk), .reset(reset), .bus(b1)
  );

  assign b0.start       = start & ~sel;
  assign b1.start       = start & sel;
  assign b0.cmd_valid   = cmd_valid & ~sel;
  assign b1.cmd_valid   = cmd_valid & sel;
  assign b0.cq_head_vld = cq_head_vld & ~sel;
  assign b1.cq_head_vld = cq_head_vld & sel;
  assign b0.num_reqs    = num_reqs;
  assign b1.num_reqs    = num_reqs;
  assign b0.sq_base     = sq_base;
  assign b1.sq_base     = sq_base;
  assign b0.cmd_data    = cmd_data;
  assign b1.cmd_data    = cmd_data;
  assign b0.sq_wr_ready = sq_wr_ready;
  assign b1.sq_wr_ready = sq_wr_ready;
  assign b0.db_ready    = db_ready;
  assign b1.db_ready    = db_ready;
  assign b0.cq_head     = cq_head;
  assign b1.cq_head     = cq_head;

  assign done        = sel ? b1.done        : b0.done;
  assign cmd_ready   = sel ? b1.cmd_ready   : b0.cmd_ready;
  assign sq_wr_valid = sel ? b1.sq_wr_valid : b0.sq_wr_valid;
  assign sq_wr_addr  = sel ? b1.sq_wr_addr  : b0.sq_wr_addr;
  assign sq_wr_data  = sel ? b1.sq_wr_data  : b0.sq_wr_data;
  assign db_valid    = sel ? b1.db_valid    : b0.db_valid;
  assign db_tail     = sel ? b1.db_tail     : b0.db_tail;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Command source: advance the queue one cycle after an accepted handshake.
  logic [63:0] cmd_q[$];
  bit          cmd_fire;
  always begin
    @(negedge aclk);
    cmd_fire = cmd_valid && cmd_ready;
    @(posedge aclk);
    #1;
    if (cmd_fire && (cmd_q.size() > 0)) void'(cmd_q.pop_front());
    cmd_valid   = (cmd_q.size() > 0);
    cmd_data    = (cmd_q.size() > 0) ? cmd_q[0] : 64'd0;
    sq_wr_ready = wr_hold ? 1'b0 : (stall ? 1'($urandom_range(1, 0)) : 1'b1);
    db_ready    = stall ? 1'($urandom_range(1, 0)) : 1'b1;
  end

  // Output monitor: records handshakes and checks payload stability under stall.
  logic [63:0] wa_q[$];
  logic [63:0] wd_q[$];
  logic [15:0] dbt_q[$];
  int          done_n = 0;
  int          act_n  = 0;
  bit          wr_stall_prev = 0;
  bit          db_stall_prev = 0;
  logic [63:0] pa, pd;
  logic [15:0] pdt;
  always @(negedge aclk) begin
    if (!reset) begin
      if (sq_wr_valid && sq_wr_ready) begin
        wa_q.push_back(sq_wr_addr);
        wd_q.push_back(sq_wr_data);
      end
      if (db_valid && db_ready) dbt_q.push_back(db_tail);
      if (done) done_n++;
      if (cmd_ready || sq_wr_valid || db_valid) act_n++;
      if (wr_stall_prev) begin
        chk("wr_valid_hold", 64'(sq_wr_valid), 64'd1);
        chk("wr_addr_hold", sq_wr_addr, pa);
        chk("wr_data_hold", sq_wr_data, pd);
      end
      if (db_stall_prev) begin
        chk("db_valid_hold", 64'(db_valid), 64'd1);
        chk("db_tail_hold", 64'(db_tail), 64'(pdt));
      end
    end
    wr_stall_prev = !reset && sq_wr_valid && !sq_wr_ready;
    db_stall_prev = !reset && db_valid && !db_ready;
    pa  = sq_wr_addr;
    pd  = sq_wr_data;
    pdt = db_tail;
  end

  task automatic clr();
    wa_q.delete();
    wd_q.delete();
    dbt_q.delete();
    done_n = 0;
    act_n  = 0;
  endtask

  task automatic do_reset(input logic s);
    @(negedge aclk);
    reset = 1'b1;
    @(negedge aclk);
    sel     = s;
    stall   = 1'b0;
    wr_hold = 1'b0;
    cmd_q.delete();
    repeat (2) @(negedge aclk);
    reset = 1'b0;
  endtask

  task automatic pulse_start(input logic [31:0] n, input logic [63:0] base);
    @(posedge aclk);
    #1;
    start    = 1'b1;
    num_reqs = n;
    sq_base  = base;
    @(posedge aclk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen;
    seen = 0;
    for (int n = 0; (n < budget) && !seen; n++) begin
      @(negedge aclk);
      seen = done;
    end
    chk(tag, 64'(seen), 64'd1);
  endtask

  task automatic out_zero(input string tag);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd0);
    chk({tag, "_wr_valid"}, 64'(sq_wr_valid), 64'd0);
    chk({tag, "_wr_addr"}, sq_wr_addr, 64'd0);
    chk({tag, "_wr_data"}, sq_wr_data, 64'd0);
    chk({tag, "_db_valid"}, 64'(db_valid), 64'd0);
    chk({tag, "_db_tail"}, 64'(db_tail), 64'd0);
  endtask

  initial begin
    bit seen;
    logic [63:0] b5;

    repeat (3) @(negedge aclk);
    out_zero("rst");
    @(negedge aclk);
    reset = 1'b0;

    // T1: three commands, one ring at tail 3.
    clr();
    cmd_q = '{64'hA, 64'hB, 64'hC};
    pulse_start(32'd3, 64'h1_0000);
    wait_done("t1_done_seen", 200);
    repeat (2) @(negedge aclk);
    chk("t1_nwr", 64'(wa_q.size()), 64'd3);
    if (wa_q.size() == 3) begin
      chk("t1_addr0", wa_q[0], 64'h1_0000);
      chk("t1_addr1", wa_q[1], 64'h1_0008);
      chk("t1_addr2", wa_q[2], 64'h1_0010);
      chk("t1_data0", wd_q[0], 64'hA);
      chk("t1_data1", wd_q[1], 64'hB);
      chk("t1_data2", wd_q[2], 64'hC);
    end
    chk("t1_nring", 64'(dbt_q.size()), 64'd1);
    if (dbt_q.size() == 1) chk("t1_db_tail", 64'(dbt_q[0]), 64'd3);
    chk("t1_ndone", 64'(done_n), 64'd1);

    // T2: empty job completes two cycles after start with no bus activity.
    clr();
    pulse_start(32'd0, 64'h9999);
    @(negedge aclk);
    chk("t2_done_c1", 64'(done), 64'd0);
    @(negedge aclk);
    chk("t2_done_c2", 64'(done), 64'd1);
    @(negedge aclk);
    chk("t2_done_c3", 64'(done), 64'd0);
    chk("t2_activity", 64'(act_n), 64'd0);
    chk("t2_ndone", 64'(done_n), 64'd1);

    // T3: 20 commands from tail 0 -> rings at 8, 16, 20.
    do_reset(1'b0);
    clr();
    for (int i = 0; i < 20; i++) cmd_q.push_back(64'h100 + 64'(i));
    pulse_start(32'd20, 64'h2000_0000);
    wait_done("t3_done_seen", 400);
    chk("t3_rings_before_done", 64'(dbt_q.size()), 64'd3);
    repeat (2) @(negedge aclk);
    chk("t3_nwr", 64'(wa_q.size()), 64'd20);
    if (wa_q.size() == 20) begin
      for (int i = 0; i < 20; i++) begin
        chk("t3_addr", wa_q[i], 64'h2000_0000 + 64'(8 * i));
        chk("t3_data", wd_q[i], 64'h100 + 64'(i));
      end
    end
    if (dbt_q.size() == 3) begin
      chk("t3_ring0", 64'(dbt_q[0]), 64'd8);
      chk("t3_ring1", 64'(dbt_q[1]), 64'd16);
      chk("t3_ring2", 64'(dbt_q[2]), 64'd20);
    end
    chk("t3_ndone", 64'(done_n), 64'd1);

    // T4: 4-deep SQ with head 0 fills after 3 entries and blocks until head moves.
    do_reset(1'b1);
    clr();
    for (int i = 0; i < 5; i++) cmd_q.push_back(64'hD0 + 64'(i));
    pulse_start(32'd5, 64'h3000);
    seen = 0;
    for (int n = 0; (n < 100) && !seen; n++) begin
      @(negedge aclk);
      seen = (dbt_q.size() >= 1);
    end
    chk("t4_ring_seen", 64'(seen), 64'd1);
    repeat (3) @(negedge aclk);
    chk("t4_full_nwr", 64'(wa_q.size()), 64'd3);
    if (wa_q.size() == 3) chk("t4_addr2", wa_q[2], 64'h3010);
    if (dbt_q.size() == 1) chk("t4_ring0", 64'(dbt_q[0]), 64'd3);
    for (int n = 0; n < 3; n++) begin
      @(negedge aclk);
      chk("t4_ready_full", 64'(cmd_ready), 64'd0);
    end
    // Head index 5 is out of range for a 4-deep SQ and must not unblock it.
    @(posedge aclk);
    #1;
    cq_head_vld = 1'b1;
    cq_head     = 16'd5;
    @(posedge aclk);
    #1;
    cq_head_vld = 1'b0;
    repeat (4) @(negedge aclk);
    chk("t4_bad_head_ready", 64'(cmd_ready), 64'd0);
    chk("t4_bad_head_nwr", 64'(wa_q.size()), 64'd3);
    @(posedge aclk);
    #1;
    cq_head_vld = 1'b1;
    cq_head     = 16'd2;
    @(posedge aclk);
    #1;
    cq_head_vld = 1'b0;
    wait_done("t4_done_seen", 100);
    repeat (2) @(negedge aclk);
    chk("t4_nwr", 64'(wa_q.size()), 64'd5);
    if (wa_q.size() == 5) begin
      chk("t4_addr3", wa_q[3], 64'h3018);
      chk("t4_addr4", wa_q[4], 64'h3000);
      chk("t4_data4", wd_q[4], 64'hD4);
    end
    chk("t4_nring", 64'(dbt_q.size()), 64'd2);
    if (dbt_q.size() == 2) chk("t4_ring1", 64'(dbt_q[1]), 64'd1);
    chk("t4_ndone", 64'(done_n), 64'd1);

    // T5: random stalls, address wrapping past 2^64, and an ignored mid-job start.
    do_reset(1'b0);
    clr();
    stall = 1'b1;
    b5 = 64'hFFFF_FFFF_FFFF_FFF0;
    for (int i = 0; i < 12; i++) cmd_q.push_back(64'hC0DE_0000 + 64'(i));
    pulse_start(32'd12, b5);
    repeat (6) @(negedge aclk);
    pulse_start(32'd99, 64'h7777_0000);
    wait_done("t5_done_seen", 1500);
    repeat (20) @(negedge aclk);
    stall = 1'b0;
    chk("t5_nwr", 64'(wa_q.size()), 64'd12);
    if (wa_q.size() == 12) begin
      for (int i = 0; i < 12; i++) begin
        chk("t5_addr", wa_q[i], b5 + 64'(8 * i));
        chk("t5_data", wd_q[i], 64'hC0DE_0000 + 64'(i));
      end
    end
    chk("t5_nring", 64'(dbt_q.size()), 64'd2);
    if (dbt_q.size() == 2) begin
      chk("t5_ring0", 64'(dbt_q[0]), 64'd8);
      chk("t5_ring1", 64'(dbt_q[1]), 64'd12);
    end
    chk("t5_ndone", 64'(done_n), 64'd1);

    // T6: reset while a write is pending, then a fresh job starts at tail 0.
    do_reset(1'b0);
    clr();
    wr_hold = 1'b1;
    cmd_q = '{64'h55, 64'h66};
    pulse_start(32'd2, 64'h5000);
    seen = 0;
    for (int n = 0; (n < 50) && !seen; n++) begin
      @(negedge aclk);
      seen = sq_wr_valid;
    end
    chk("t6_wr_seen", 64'(seen), 64'd1);
    chk("t6_addr_pre", sq_wr_addr, 64'h5000);
    reset = 1'b1;
    @(negedge aclk);
    out_zero("t6_abort");
    repeat (2) @(negedge aclk);
    wr_hold = 1'b0;
    cmd_q.delete();
    reset = 1'b0;
    repeat (5) @(negedge aclk);
    chk("t6_no_done", 64'(done_n), 64'd0);
    chk("t6_no_wr", 64'(wa_q.size()), 64'd0);
    clr();
    cmd_q = '{64'h77};
    pulse_start(32'd1, 64'h5000);
    wait_done("t6_done_seen", 100);
    repeat (2) @(negedge aclk);
    chk("t6_nwr", 64'(wa_q.size()), 64'd1);
    if (wa_q.size() == 1) begin
      chk("t6_addr", wa_q[0], 64'h5000);
      chk("t6_data", wd_q[0], 64'h77);
    end
    if (dbt_q.size() == 1) chk("t6_ring", 64'(dbt_q[0]), 64'd1);
    chk("t6_ndone", 64'(done_n), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
